apb_rr_master: RTL

APB_RR_MASTER -- requirements
Module: apb_rr_master

---
 rtl/apb_rr_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/apb_rr_master.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/apb_rr_pkg.sv
// Shared types and default sizing for the round-robin APB master.
package apb_rr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_AW      = 32;
  localparam int unsigned DEF_DW      = 32;
  localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first unmasked request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [NREQ-1:0] elig;
  logic [IW-1:0]   pos;

  assign elig = req & ~mask;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = IW'((32'(ptr) + k) % 32'(NREQ));
      if (!valid && elig[pos]) begin
        valid      = 1'b1;
        idx        = pos;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB requester that serialises NREQ local requesters onto one bus, round-robin,
// with a bounded ACCESS phase and a one-cycle completion pulse per transfer.
module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [AW-1:0]     paddr,
  output logic [DW-1:0]     pwdata,
  input  logic [DW-1:0]     prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  apb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            psel_d, penable_d, pwrite_d, rsp_err_d;
  logic [AW-1:0]   paddr_d;
  logic [DW-1:0]   pwdata_d, rsp_rdata_d;
  logic [NREQ-1:0] done_d;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;

  logic [AW-1:0]   addr_a  [NREQ];
  logic [DW-1:0]   wdata_a [NREQ];

  always_comb begin
    for (int unsigned n = 0; n < NREQ; n++) begin
      addr_a[n]  = req_addr[n*AW +: AW];
      wdata_a[n] = req_wdata[n*DW +: DW];
    end
  end

  // The registered done pulse doubles as the mask, so a requester that is
  // still holding req in its completion cycle cannot win that cycle's pick.
  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req),
    .mask  (done),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    done_d      = '0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          paddr_d  = addr_a[arb_idx];
          pwdata_d = wdata_a[arb_idx];
          pwrite_d = req_write[arb_idx];
          gnt_d    = arb_grant;
          ptr_d    = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          done_d      = gnt_q;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite ? '0 : prdata;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d     = IDLE;
          done_d      = gnt_q;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      done      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      done      <= done_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule
